// File: rtl/rd_act_pkg.sv
// ============================================================================
//  Module   : rd_act_pkg
//  Brief    : Shared state encoding and parameter defaults for rd_act_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rd_act_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int c_nch     = 4;
    localparam int c_act_lat = 2;
    localparam int c_cnt_w   = 8;

endpackage

`default_nettype wire

// File: rtl/rd_act_delay_line.sv
// ============================================================================
//  Module   : rd_act_delay_line
//  Brief    : WIDTH x DEPTH enabled shift register with synchronous flush and
//             an any-stage-nonzero flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_act_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             any_nz
);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic             w_any;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (en) begin
            for (int i = DEPTH - 1; i > 0; i--) r_stage[i] <= r_stage[i-1];
            r_stage[0] <= din;
        end
    end

    always_comb begin
        w_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) w_any = w_any | (|r_stage[i]);
    end

    assign dout   = r_stage[DEPTH-1];
    assign any_nz = w_any;

endmodule

`default_nettype wire

// File: rtl/rd_act_sequencer.sv
// ============================================================================
//  Module   : rd_act_sequencer
//  Brief    : Multi-channel burst sequencer: per-channel rd strobes followed by
//             act strobes ACT_LAT enabled cycles later. Define ACT_FLUSH_EN to
//             discard in-flight acts on early terminate.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_act_sequencer
    import rd_act_pkg::*;
#(
    parameter int NCH     = c_nch,
    parameter int ACT_LAT = c_act_lat,
    parameter int CNT_W   = c_cnt_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             done,
    output logic [NCH-1:0]   rd,
    output logic [NCH-1:0]   act,
    output logic             busy,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             burst_done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [NCH-1:0]   r_mask;
    logic             r_zero_done;

    logic             w_issue;
    logic             w_accept;
    logic             w_flush;
    logic             w_drained;
    logic             w_pipe_nz;
    logic [NCH-1:0]   w_pipe_out;

    assign w_issue   = (r_state == READ) && en && !done;
    assign w_accept  = (r_state == IDLE) && start && (len != '0);
    assign w_drained = (r_state == DRAIN) && en && !w_pipe_nz;

`ifdef ACT_FLUSH_EN
    assign w_flush = (r_state == READ) && done;
`else
    assign w_flush = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = READ;
            // done wins over a simultaneous final read
            READ:    if (done || (w_issue && r_remaining == CNT_W'(1)))
                         w_state_nxt = DRAIN;
            DRAIN:   if (w_drained) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_rd_cnt    <= '0;
            r_mask      <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_zero_done <= (r_state == IDLE) && start && (len == '0);
            if (w_accept) begin
                r_remaining <= len;
                r_mask      <= ch_mask;
                r_rd_cnt    <= '0;
            end else if (w_issue) begin
                r_remaining <= r_remaining - CNT_W'(1);
                r_rd_cnt    <= r_rd_cnt + CNT_W'(1);
            end
        end
    end

    rd_act_delay_line #(
        .WIDTH (NCH),
        .DEPTH (ACT_LAT)
    ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .flush  (w_flush),
        .din    (rd),
        .dout   (w_pipe_out),
        .any_nz (w_pipe_nz)
    );

    assign rd         = w_issue ? r_mask : '0;
    // a flushing cycle also suppresses the act already at the pipe output
    assign act        = w_pipe_out & {NCH{en & ~w_flush}};
    assign busy       = (r_state != IDLE);
    assign rd_cnt     = r_rd_cnt;
    assign burst_done = w_drained | r_zero_done;

endmodule

`default_nettype wire

// File: tb/tb_rd_act_sequencer.sv
// ============================================================================
//  Module   : tb_rd_act_sequencer
//  Brief    : Directed self-checking bench for rd_act_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rd_act_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, start, done;
    logic [7:0] len;
    logic [3:0] ch_mask;
    logic [3:0] rd, act;
    logic       busy, burst_done;
    logic [7:0] rd_cnt;

    logic       en2, start2, done2;
    logic [7:0] len2;
    logic [0:0] mask2, rd2, act2;
    logic       busy2, bd2;
    logic [7:0] rd_cnt2;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    rd_act_sequencer #(.NCH(4), .ACT_LAT(2), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .len(len),
        .ch_mask(ch_mask), .done(done), .rd(rd), .act(act), .busy(busy),
        .rd_cnt(rd_cnt), .burst_done(burst_done)
    );

    rd_act_sequencer #(.NCH(1), .ACT_LAT(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .en(en2), .start(start2), .len(len2),
        .ch_mask(mask2), .done(done2), .rd(rd2), .act(act2), .busy(busy2),
        .rd_cnt(rd_cnt2), .burst_done(bd2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle n=0 is the start cycle t; bit n of each mask marks cycle t+n.
    task automatic run_burst(input string name, input logic [7:0] blen, input logic [3:0] bmask,
                             input int en_off, input int done_at, input int start2_at,
                             input logic [15:0] rd_m, input logic [15:0] act_m,
                             input logic [15:0] bd_m, input logic [15:0] busy_m,
                             input int ncyc, input int chk_cnt, input logic [7:0] exp_cnt);
        for (int n = 0; n < ncyc; n++) begin
            start   = (n == 0) || (n == start2_at);
            len     = (n == 0) ? blen  : 8'd7;
            ch_mask = (n == 0) ? bmask : 4'hF;
            en      = (n != en_off);
            done    = (n == done_at);
            @(negedge clk);
            check_val($sformatf("%s rd c%0d", name, n), 32'(rd), rd_m[n] ? 32'(bmask) : 32'd0);
            check_val($sformatf("%s act c%0d", name, n), 32'(act), act_m[n] ? 32'(bmask) : 32'd0);
            check_val($sformatf("%s busy c%0d", name, n), 32'(busy), 32'(busy_m[n]));
            check_val($sformatf("%s burst_done c%0d", name, n), 32'(burst_done), 32'(bd_m[n]));
            @(posedge clk);
            #1;
        end
        start = 1'b0; en = 1'b1; done = 1'b0;
        if (chk_cnt != 0)
            check_val($sformatf("%s rd_cnt", name), 32'(rd_cnt), 32'(exp_cnt));
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; start = 1'b0; done = 1'b0; len = '0; ch_mask = '0;
        en2 = 1'b1; start2 = 1'b0; done2 = 1'b0; len2 = '0; mask2 = '0;
        #2;
        check_val("reset rd", 32'(rd), 0);
        check_val("reset act", 32'(act), 0);
        check_val("reset busy", 32'(busy), 0);
        check_val("reset rd_cnt", 32'(rd_cnt), 0);
        check_val("reset burst_done", 32'(burst_done), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        run_burst("basic", 8'd3, 4'b0101, -1, -1, -1,
                  16'h000E, 16'h0038, 16'h0040, 16'h007E, 8, 1, 8'd3);
        run_burst("stall", 8'd3, 4'b0101, 2, -1, -1,
                  16'h001A, 16'h0070, 16'h0080, 16'h00FE, 9, 1, 8'd3);
`ifdef ACT_FLUSH_EN
        run_burst("early", 8'd5, 4'b1010, -1, 3, -1,
                  16'h0006, 16'h0000, 16'h0010, 16'h001E, 7, 1, 8'd2);
`else
        run_burst("early", 8'd5, 4'b1010, -1, 3, -1,
                  16'h0006, 16'h0018, 16'h0020, 16'h003E, 7, 1, 8'd2);
`endif
        run_burst("zero", 8'd0, 4'b1111, -1, -1, -1,
                  16'h0000, 16'h0000, 16'h0002, 16'h0000, 3, 0, 8'd0);
        run_burst("busy_start", 8'd3, 4'b0011, -1, -1, 2,
                  16'h000E, 16'h0038, 16'h0040, 16'h007E, 8, 1, 8'd3);

        // asynchronous reset in the middle of a len=4 burst
        start = 1'b1; len = 8'd4; ch_mask = 4'hF;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("pre-reset rd", 32'(rd), 32'hF);
        check_val("pre-reset act", 32'(act), 32'hF);
        #1 reset = 1'b0;
        #1;
        check_val("async rd", 32'(rd), 0);
        check_val("async act", 32'(act), 0);
        check_val("async busy", 32'(busy), 0);
        check_val("async rd_cnt", 32'(rd_cnt), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check_val($sformatf("post-reset busy c%0d", n), 32'(busy), 0);
            check_val($sformatf("post-reset burst_done c%0d", n), 32'(burst_done), 0);
        end
        @(posedge clk); #1;
        run_burst("after_reset", 8'd3, 4'b0101, -1, -1, -1,
                  16'h000E, 16'h0038, 16'h0040, 16'h007E, 8, 1, 8'd3);

        // single channel, ACT_LAT=1, full-length burst
        start2 = 1'b1; len2 = 8'd255; mask2 = 1'b1;
        for (int n = 0; n < 260; n++) begin
            @(negedge clk);
            check_val($sformatf("long c%0d", n), {29'd0, rd2, act2, bd2},
                      {29'd0, (n >= 1 && n <= 255) ? 1'b1 : 1'b0,
                       (n >= 2 && n <= 256) ? 1'b1 : 1'b0, (n == 257) ? 1'b1 : 1'b0});
            @(posedge clk); #1 start2 = 1'b0;
        end
        check_val("long rd_cnt", 32'(rd_cnt2), 32'hFF);
        check_val("long busy", 32'(busy2), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
